// File: rtl/rr_bus_arbiter_fsm.sv
// Round-robin N-requester bus arbiter with a four-phase bus FSM
// (IDLE/BBUSY/BWAIT/BFREE) and a forced release after MAX_HOLD cycles.
module rr_bus_arbiter_fsm #(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 16,
  localparam int ID_W     = $clog2(N),
  localparam int CNT_W    = $clog2(MAX_HOLD)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            done,
  input  logic            dly,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            busy,
  output logic            timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BBUSY = 2'd1,
    BWAIT = 2'd2,
    BFREE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [N-1:0]      gnt_d;
  logic [ID_W-1:0]   id_d;
  logic              busy_d, to_d;
  logic [ID_W-1:0]   win;
  logic              found;
  logic              force_rel;
  logic              cur_busy;
  logic              nxt_busy;
  logic              grant_new;
  logic              hold_lim;
  int                k;

  // Scan from last_q+1 upward, wrapping, so the last owner ranks lowest.
  always_comb begin
    found = 1'b0;
    win   = '0;
    k     = 0;
    for (int i = 1; i <= N; i++) begin
      k = int'(last_q) + i;
      if (k >= N) k = k - N;
      if (!found && req[k]) begin
        found = 1'b1;
        win   = ID_W'(k);
      end
    end
  end

  assign cur_busy = (state_q == BBUSY) || (state_q == BWAIT);
  assign hold_lim = (cnt_q == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= ID_W'(N - 1);
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt     <= gnt_d;
      gnt_id  <= id_d;
      busy    <= busy_d;
      timeout <= to_d;
    end
  end

  always_comb begin
    state_d   = IDLE;
    force_rel = 1'b0;
    unique case (state_q)
      IDLE:    state_d = |req ? BBUSY : IDLE;
      BBUSY: begin
        if (!done)    state_d = BBUSY;
        else if (dly) state_d = BWAIT;
        else          state_d = BFREE;
      end
      BWAIT:   state_d = dly ? BWAIT : BFREE;
      BFREE:   state_d = |req ? BBUSY : IDLE;
      default: state_d = IDLE;
    endcase
    // Staying on the bus past the limit becomes a forced turnaround.
    if (cur_busy && hold_lim &&
        (state_d == BBUSY || state_d == BWAIT)) begin
      state_d   = BFREE;
      force_rel = 1'b1;
    end
  end

  assign nxt_busy  = (state_d == BBUSY) || (state_d == BWAIT);
  assign grant_new = (state_d == BBUSY) && !cur_busy;

  always_comb begin
    gnt_d  = '0;
    id_d   = gnt_id;
    last_d = last_q;
    cnt_d  = cnt_q;
    busy_d = nxt_busy;
    to_d   = force_rel;
    if (grant_new) begin
      gnt_d  = N'(1) << win;
      id_d   = win;
      last_d = win;
      cnt_d  = '0;
    end else if (nxt_busy) begin
      gnt_d  = gnt;
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

endmodule
